// File: rtl/ee93_pkg.sv
// Shared opcodes, extended-command codes and FSM/pending-operation types
// for the 93xx Microwire serial EEPROM responder.
package ee93_pkg;

  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  // Extended commands are selected by the two address MSBs under OP_EXT
  localparam logic [1:0] EWEN = 2'b11;
  localparam logic [1:0] EWDS = 2'b00;
  localparam logic [1:0] ERAL = 2'b10;
  localparam logic [1:0] WRAL = 2'b01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_OPC,
    ST_ADDR,
    ST_RD_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_WAIT_CSLOW,
    ST_PROG
  } state_e;

  typedef enum logic [2:0] {
    PEND_NONE,
    PEND_WRITE,
    PEND_ERASE,
    PEND_ERAL,
    PEND_WRAL
  } pend_e;

endpackage

// File: rtl/ee93_serial_responder_if.sv
// Microwire serial link plus status taps between a controller (master)
// and the EEPROM responder (slave).
interface ee93_serial_responder_if;
  logic cs;
  logic sk;
  logic di;
  logic do_o;
  logic do_oe;
  logic busy;
  logic wen;

  modport master (output cs, sk, di, input do_o, do_oe, busy, wen);
  modport slave  (input cs, sk, di, output do_o, do_oe, busy, wen);
endinterface

// File: rtl/ee93_sync_edge.sv
// Two-flop synchroniser with a registered rising-edge pulse; an input
// edge shows up on o_rise three clk edges later.
module ee93_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);
  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
      o_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_async};
      r_prev <= r_sync[1];
      o_rise <= r_sync[1] & ~r_prev;
    end
  end
endmodule

// File: rtl/ee93_serial_responder.sv
// 93xx Microwire EEPROM responder: command decode, serial read/write,
// self-timed program phase. Define EE93_BULK_EN to enable ERAL/WRAL.
module ee93_serial_responder
  import ee93_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 6,
  parameter int unsigned        DATA_W      = 16,
  parameter int unsigned        PROG_CYCLES = 64,
  parameter logic [DATA_W-1:0]  INIT_VAL    = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  ee93_serial_responder_if.slave  bus
);
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned CNT_W  = $clog2(DATA_W + ADDR_W + 1);
  localparam int unsigned PCNT_W = $clog2(2 * PROG_CYCLES + 1);

  logic [1:0]        r_cs_sync, r_di_sync;
  logic              w_cs, w_di, w_sk_rise;
  state_e            r_state;
  pend_e             r_op;
  logic              r_pend, r_do, r_oe, r_busy, r_wen;
  logic [1:0]        r_opc;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [1:0]        w_ext;
  logic [CNT_W-1:0]  r_cnt;
  logic [PCNT_W-1:0] r_pcnt;
  logic [DATA_W-1:0] r_wdata, r_rd, w_rd_word, w_nx_word;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_commit;

  ee93_sync_edge u_sk_sync (.clk(clk), .rst(rst), .i_async(bus.sk), .o_rise(w_sk_rise));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_sync <= 2'b00;
      r_di_sync <= 2'b00;
    end else begin
      r_cs_sync <= {r_cs_sync[0], bus.cs};
      r_di_sync <= {r_di_sync[0], bus.di};
    end
  end

  assign w_cs        = r_cs_sync[1];
  assign w_di        = r_di_sync[1];
  assign w_addr_next = {r_addr[ADDR_W-2:0], w_di};
  assign w_ext       = w_addr_next[ADDR_W-1 -: 2];
  assign w_rd_word   = r_mem[r_addr];
  assign w_nx_word   = r_mem[r_addr + ADDR_W'(1)];
  assign w_commit    = (r_state == ST_WAIT_CSLOW) && !w_cs && r_pend && r_wen;

  // Array update happens on the clk edge that enters PROG
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= INIT_VAL;
    end else if (w_commit) begin
      case (r_op)
        PEND_WRITE: r_mem[r_addr] <= r_wdata;
        PEND_ERASE: r_mem[r_addr] <= '1;
`ifdef EE93_BULK_EN
        PEND_ERAL:  for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '1;
        PEND_WRAL:  for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= r_wdata;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= PEND_NONE;
      r_pend  <= 1'b0;
      r_do    <= 1'b1;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_wen   <= 1'b0;
      r_opc   <= 2'b00;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_pcnt  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else if (!w_cs && r_state != ST_PROG && r_state != ST_WAIT_CSLOW) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
      r_oe    <= 1'b0;
      r_do    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_START;
        // Leading zeros before the start bit are ignored; a status poll keeps DO until then
        ST_START: if (w_sk_rise && w_di) begin
          r_state <= ST_OPC;
          r_cnt   <= '0;
          r_oe    <= 1'b0;
          r_do    <= 1'b1;
        end
        ST_OPC: if (w_sk_rise) begin
          r_opc <= {r_opc[0], w_di};
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_ADDR;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ADDR: if (w_sk_rise) begin
          r_addr <= w_addr_next;
          if (r_cnt == CNT_W'(ADDR_W - 1)) begin
            r_state <= ST_WAIT_CSLOW;
            r_op    <= PEND_NONE;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
            case (r_opc)
              OP_READ: begin
                r_state <= ST_RD_DUMMY;
                r_oe    <= 1'b1;
                r_do    <= 1'b0;
              end
              OP_WRITE: begin
                r_state <= ST_WR_DATA;
                r_op    <= PEND_WRITE;
              end
              OP_ERASE: begin
                r_op   <= PEND_ERASE;
                r_pend <= 1'b1;
              end
              OP_EXT: case (w_ext)
                EWEN: r_wen <= 1'b1;
                EWDS: r_wen <= 1'b0;
`ifdef EE93_BULK_EN
                ERAL: begin
                  r_op   <= PEND_ERAL;
                  r_pend <= 1'b1;
                end
                WRAL: begin
                  r_state <= ST_WR_DATA;
                  r_op    <= PEND_WRAL;
                end
`else
                ERAL, WRAL: ;
`endif
                default: ;
              endcase
              default: ;
            endcase
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RD_DUMMY: if (w_sk_rise) begin
          r_state <= ST_RD_DATA;
          r_do    <= w_rd_word[DATA_W-1];
          r_rd    <= {w_rd_word[DATA_W-2:0], 1'b0};
          r_cnt   <= CNT_W'(DATA_W - 1);
        end
        // After the LSB the address wraps and the next word streams out
        ST_RD_DATA: if (w_sk_rise) begin
          if (r_cnt == '0) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_do   <= w_nx_word[DATA_W-1];
            r_rd   <= {w_nx_word[DATA_W-2:0], 1'b0};
            r_cnt  <= CNT_W'(DATA_W - 1);
          end else begin
            r_do  <= r_rd[DATA_W-1];
            r_rd  <= {r_rd[DATA_W-2:0], 1'b0};
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_WR_DATA: if (w_sk_rise) begin
          r_wdata <= {r_wdata[DATA_W-2:0], w_di};
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state <= ST_WAIT_CSLOW;
            r_pend  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_CSLOW: if (!w_cs) begin
          r_pend <= 1'b0;
          r_oe   <= 1'b0;
          r_do   <= 1'b1;
          if (r_pend && r_wen) begin
            r_state <= ST_PROG;
            r_busy  <= 1'b1;
            r_pcnt  <= (r_op == PEND_ERAL || r_op == PEND_WRAL) ?
                       PCNT_W'(2 * PROG_CYCLES - 1) : PCNT_W'(PROG_CYCLES - 1);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        // Commands are ignored while programming; only busy status is driven
        ST_PROG: begin
          r_oe <= w_cs;
          if (r_pcnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_do    <= 1'b1;
          end else begin
            r_pcnt <= r_pcnt - PCNT_W'(1);
            r_do   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.do_o  = r_do;
  assign bus.do_oe = r_oe;
  assign bus.busy  = r_busy;
  assign bus.wen   = r_wen;
endmodule

// File: tb/tb_ee93_serial_responder.sv
// Directed bench for ee93_serial_responder: Microwire frames driven from
// tasks, DO sampled after each SK pulse, expected values hand-computed.
module tb_ee93_serial_responder;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ee93_serial_responder_if bus ();

  ee93_serial_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SK high and low each last 6 clk; DI set up 3 clk ahead of the rise
  task automatic sk_pulse(input logic b);
    bus.di = b;
    tick(3);
    bus.sk = 1'b1;
    tick(6);
    bus.sk = 1'b0;
    tick(3);
  endtask

  task automatic send_cmd(input logic [1:0] opc, input logic [5:0] addr);
    bus.cs = 1'b1;
    tick(4);
    sk_pulse(1'b0);
    sk_pulse(1'b1);
    for (int i = 1; i >= 0; i--) sk_pulse(opc[i]);
    for (int i = 5; i >= 0; i--) sk_pulse(addr[i]);
  endtask

  task automatic send_data(input logic [15:0] d, input int nbits);
    for (int i = 15; i > 15 - nbits; i--) sk_pulse(d[i]);
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    bus.di = 1'b0;
    tick(6);
  endtask

  task automatic read_chk(input string tag, input logic [5:0] addr, input int nbits,
                          input logic [31:0] exp);
    logic [31:0] val;
    send_cmd(2'b10, addr);
    check({tag, "_dummy_do"}, 32'(bus.do_o), 32'd0);
    check({tag, "_dummy_oe"}, 32'(bus.do_oe), 32'd1);
    val = '0;
    for (int i = 0; i < nbits; i++) begin
      sk_pulse(1'b0);
      val = {val[30:0], bus.do_o};
    end
    check(tag, val, exp);
    cs_low();
    check({tag, "_oe_off"}, 32'(bus.do_oe), 32'd0);
  endtask

  // Drops cs, measures busy length; optionally polls status with cs high
  task automatic prog_run(input string tag, input int exp_len, input bit poll);
    int w;
    int n;
    w = 0;
    n = 0;
    bus.cs = 1'b0;
    bus.di = 1'b0;
    while (!bus.busy && w < 30) begin
      @(negedge clk);
      w++;
    end
    if (poll && bus.busy) bus.cs = 1'b1;
    while (bus.busy && n < 1000) begin
      if (poll && n == 20) begin
        check({tag, "_poll_oe"}, 32'(bus.do_oe), 32'd1);
        check({tag, "_poll_busy_do"}, 32'(bus.do_o), 32'd0);
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_len"}, 32'(n), 32'(exp_len));
    if (poll) begin
      tick(3);
      check({tag, "_ready_do"}, 32'(bus.do_o), 32'd1);
      check({tag, "_ready_oe"}, 32'(bus.do_oe), 32'd1);
      bus.cs = 1'b0;
    end
    tick(6);
    if (poll) check({tag, "_oe_after"}, 32'(bus.do_oe), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    bus.cs = 1'b0;
    bus.sk = 1'b0;
    bus.di = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_do",    32'(bus.do_o),  32'd1);
    check("rst_oe",    32'(bus.do_oe), 32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_wen",   32'(bus.wen),   32'd0);

    read_chk("rd05_erased", 6'h05, 16, 32'h0000_FFFF);

    send_cmd(2'b01, 6'h05);
    send_data(16'hA5C3, 16);
    prog_run("wr_nowen", 0, 1'b0);
    read_chk("rd05_nowen", 6'h05, 16, 32'h0000_FFFF);

    send_cmd(2'b00, 6'b110000);
    cs_low();
    check("ewen_wen", 32'(bus.wen), 32'd1);

    send_cmd(2'b01, 6'h05);
    send_data(16'hA5C3, 16);
    prog_run("wr05", 64, 1'b1);
    read_chk("rd05_seq", 6'h05, 32, 32'hA5C3_FFFF);

    send_cmd(2'b01, 6'h3F);
    send_data(16'h8001, 16);
    prog_run("wr3f", 64, 1'b0);
    send_cmd(2'b01, 6'h00);
    send_data(16'h3C5A, 16);
    prog_run("wr00", 64, 1'b0);
    read_chk("rd3f_wrap", 6'h3F, 32, 32'h8001_3C5A);

    send_cmd(2'b01, 6'h05);
    send_data(16'h0000, 9);
    prog_run("wr_partial", 0, 1'b0);
    read_chk("rd05_partial", 6'h05, 16, 32'h0000_A5C3);

    send_cmd(2'b11, 6'h05);
    prog_run("erase05", 64, 1'b0);
    read_chk("rd05_erase", 6'h05, 16, 32'h0000_FFFF);

    send_cmd(2'b00, 6'b010000);
    send_data(16'h1234, 16);
`ifdef EE93_BULK_EN
    prog_run("wral", 128, 1'b0);
    read_chk("rd00_wral", 6'h00, 16, 32'h0000_1234);
    read_chk("rd3f_wral", 6'h3F, 16, 32'h0000_1234);
`else
    prog_run("wral_off", 0, 1'b0);
    read_chk("rd00_wral_off", 6'h00, 16, 32'h0000_3C5A);
    read_chk("rd3f_wral_off", 6'h3F, 16, 32'h0000_8001);
`endif

    send_cmd(2'b00, 6'b000000);
    cs_low();
    check("ewds_wen", 32'(bus.wen), 32'd0);
    send_cmd(2'b01, 6'h07);
    send_data(16'h0F0F, 16);
    prog_run("wr_after_ewds", 0, 1'b0);
    read_chk("rd07_ewds", 6'h07, 16, 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
